// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, return-address stack and the
// fetch / decode / update strobes that pace the instruction register.
module pc_sequencer #(
   parameter int unsigned PC_W         = 10,
   parameter int unsigned STACK_DEPTH  = 8,
   parameter int unsigned RESET_VECTOR = 0
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            HOLD,
   input  logic            bsr_det,
   input  logic            ret_det,
   input  logic [9:0]      relative_jump,
   output logic [PC_W-1:0] pc,
   output logic            enable_current,
   output logic            enable_next,
   output logic [3:0]      sp,
   output logic            fault,
   output logic [1:0]      fault_code
);

   localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

   localparam logic [1:0] S_FETCH  = 2'd0;
   localparam logic [1:0] S_DECODE = 2'd1;
   localparam logic [1:0] S_UPDATE = 2'd2;
   localparam logic [1:0] S_HALT   = 2'd3;

   localparam logic [1:0] FC_NONE = 2'b00;
   localparam logic [1:0] FC_OVF  = 2'b01;
   localparam logic [1:0] FC_UNF  = 2'b10;

   logic [1:0]      state_q, state_d;
   // pend: the current state has not executed yet (after reset or HOLD)
   logic            pend_q, pend_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic            en_cur_q, en_cur_d;
   logic            en_nxt_q, en_nxt_d;
   logic            fault_q, fault_d;
   logic [1:0]      code_q, code_d;
   logic [PC_W-1:0] dec_pc_q, dec_pc_d;
   logic            dec_push_q, dec_push_d;
   logic            dec_pop_q, dec_pop_d;

   logic [PC_W-1:0] stack_q [STACK_DEPTH];
   logic            push_we;
   logic [IDX_W-1:0] push_idx;
   logic [IDX_W-1:0] pop_idx;
   logic [PC_W-1:0] rj_ext;

   assign push_idx = IDX_W'(sp_q);
   assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
   assign rj_ext   = PC_W'($signed(relative_jump));

   assign pc             = pc_q;
   assign enable_current = en_cur_q;
   assign enable_next    = en_nxt_q;
   assign sp             = 4'(sp_q);
   assign fault          = fault_q;
   assign fault_code     = code_q;

   // next-state, next-pc and strobe decode
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      pc_d       = pc_q;
      sp_d       = sp_q;
      en_cur_d   = 1'b0;
      en_nxt_d   = 1'b0;
      fault_d    = fault_q;
      code_d     = code_q;
      dec_pc_d   = dec_pc_q;
      dec_push_d = dec_push_q;
      dec_pop_d  = dec_pop_q;
      push_we    = 1'b0;
      if (state_q != S_HALT) begin
         if (HOLD) begin
            pend_d = 1'b1;
         end else if (pend_q) begin
            pend_d   = 1'b0;
            en_cur_d = (state_q == S_FETCH);
            en_nxt_d = (state_q == S_UPDATE);
         end else begin
            case (state_q)
               S_FETCH: begin
                  state_d = S_DECODE;
               end
               S_DECODE: begin
                  dec_push_d = 1'b0;
                  dec_pop_d  = 1'b0;
                  if (ret_det) begin
                     if (sp_q == '0) begin
                        fault_d = 1'b1;
                        code_d  = FC_UNF;
                        state_d = S_HALT;
                     end else begin
                        dec_pc_d  = stack_q[pop_idx];
                        dec_pop_d = 1'b1;
                        state_d   = S_UPDATE;
                        en_nxt_d  = 1'b1;
                     end
                  end else if (bsr_det) begin
                     if (sp_q == SP_W'(STACK_DEPTH)) begin
                        fault_d = 1'b1;
                        code_d  = FC_OVF;
                        state_d = S_HALT;
                     end else begin
                        dec_pc_d   = pc_q + rj_ext;
                        dec_push_d = 1'b1;
                        state_d    = S_UPDATE;
                        en_nxt_d   = 1'b1;
                     end
                  end else begin
                     dec_pc_d = pc_q + PC_W'(1);
                     state_d  = S_UPDATE;
                     en_nxt_d = 1'b1;
                  end
               end
               S_UPDATE: begin
                  pc_d = dec_pc_q;
                  if (dec_push_q) begin
                     push_we = 1'b1;
                     sp_d    = sp_q + SP_W'(1);
                  end else if (dec_pop_q) begin
                     sp_d = sp_q - SP_W'(1);
                  end
                  state_d  = S_FETCH;
                  en_cur_d = 1'b1;
               end
               default: begin
                  state_d = S_HALT;
               end
            endcase
         end
      end
   end

   // state, pc, sp, strobe and fault registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_FETCH;
         pend_q     <= 1'b1;
         pc_q       <= PC_W'(RESET_VECTOR);
         sp_q       <= '0;
         en_cur_q   <= 1'b0;
         en_nxt_q   <= 1'b0;
         fault_q    <= 1'b0;
         code_q     <= FC_NONE;
         dec_pc_q   <= '0;
         dec_push_q <= 1'b0;
         dec_pop_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pc_q       <= pc_d;
         sp_q       <= sp_d;
         en_cur_q   <= en_cur_d;
         en_nxt_q   <= en_nxt_d;
         fault_q    <= fault_d;
         code_q     <= code_d;
         dec_pc_q   <= dec_pc_d;
         dec_push_q <= dec_push_d;
         dec_pop_q  <= dec_pop_d;
      end
   end

   // return-address storage; contents are don't-care after reset
   always_ff @(posedge CLK) begin
      if (push_we) begin
         stack_q[push_idx] <= pc_q + PC_W'(1);
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver answers each fetch strobe with
// an instruction and predicts the next fetch address; a monitor compares.
module tb_pc_sequencer;

   localparam int unsigned PC_W   = 10;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned RV     = 0;
   localparam int          PC_MOD = 1 << PC_W;

   logic            CLK = 1'b0;
   logic            RESET_N = 1'b1;
   logic            HOLD = 1'b0;
   logic            bsr_det = 1'b0;
   logic            ret_det = 1'b0;
   logic [9:0]      relative_jump = '0;
   logic [PC_W-1:0] pc;
   logic            enable_current;
   logic            enable_next;
   logic [3:0]      sp;
   logic            fault;
   logic [1:0]      fault_code;

   pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .HOLD(HOLD),
      .bsr_det(bsr_det), .ret_det(ret_det), .relative_jump(relative_jump),
      .pc(pc), .enable_current(enable_current), .enable_next(enable_next),
      .sp(sp), .fault(fault), .fault_code(fault_code)
   );

   always #5 CLK = ~CLK;

   typedef struct { bit b; bit r; bit [9:0] rj; } stim_t;
   typedef struct { int pc; int sp; } exp_t;

   stim_t stim_q[$];
   exp_t  exp_q[$];
   int    m_pc;
   int    m_stack[$];
   bit    m_halted;
   int    m_code;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit disturbed = 1'b1;
   int last_fetch = 0;
   int nxt_cnt = 0;

   function automatic stim_t mk(bit b, bit r, bit [9:0] rj);
      stim_t s;
      s.b = b; s.r = r; s.rj = rj;
      return s;
   endfunction

   task automatic check(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   always @(posedge CLK) cyc++;

   // instruction-register model and reference model of the program flow
   always @(negedge CLK) begin
      stim_t s;
      exp_t  e;
      int    rj_int;
      if (RESET_N && enable_current && !m_halted) begin
         if (stim_q.size() > 0) s = stim_q.pop_front();
         else s = mk(1'b0, 1'b0, 10'd0);
         bsr_det = s.b;
         ret_det = s.r;
         relative_jump = s.rj;
         if (s.r) begin
            if (m_stack.size() == 0) begin m_halted = 1'b1; m_code = 2; end
            else m_pc = m_stack.pop_back();
         end else if (s.b) begin
            if (m_stack.size() == DEPTH) begin m_halted = 1'b1; m_code = 1; end
            else begin
               m_stack.push_back((m_pc + 1) % PC_MOD);
               rj_int = (int'(s.rj) >= 512) ? int'(s.rj) - 1024 : int'(s.rj);
               m_pc = (m_pc + rj_int + PC_MOD) % PC_MOD;
            end
         end else begin
            m_pc = (m_pc + 1) % PC_MOD;
         end
         if (!m_halted) begin
            e.pc = m_pc;
            e.sp = m_stack.size();
            exp_q.push_back(e);
         end
      end
   end

   // monitor: every fetch strobe is checked against the oldest prediction
   always @(negedge CLK) begin
      exp_t e;
      if (RESET_N) begin
         if (enable_next) nxt_cnt++;
         if (enable_current) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_fetch: strobe at pc 0x%0h, expected no fetch", pc);
            end else begin
               e = exp_q.pop_front();
               check("fetch_pc", int'(pc), e.pc);
               check("fetch_sp", int'(sp), e.sp);
            end
            if (!disturbed) begin
               check("fetch_gap", cyc - last_fetch, 3);
               check("update_strobes", nxt_cnt, 1);
            end
            disturbed = 1'b0;
            last_fetch = cyc;
            nxt_cnt = 0;
         end
      end
   end

   task automatic reset_dut();
      exp_t e;
      RESET_N = 1'b0;
      HOLD = 1'b0;
      bsr_det = 1'b0;
      ret_det = 1'b0;
      relative_jump = '0;
      stim_q.delete();
      exp_q.delete();
      m_stack.delete();
      m_pc = RV;
      m_halted = 1'b0;
      m_code = 0;
      disturbed = 1'b1;
      e.pc = RV;
      e.sp = 0;
      exp_q.push_back(e);
      @(negedge CLK);
      check("rst_pc", int'(pc), RV);
      check("rst_sp", int'(sp), 0);
      check("rst_strobes", int'({enable_current, enable_next}), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_code", int'(fault_code), 0);
      RESET_N = 1'b1;
   endtask

   task automatic wait_fetch(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge CLK);
         if (enable_current) ok = 1'b1;
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL fetch_timeout: no enable_current within 60 cycles");
      end
   endtask

   task automatic wait_drain(int budget);
      int n = 0;
      while (stim_q.size() > 0 && n < budget) begin @(negedge CLK); n++; end
      check("drain_left", stim_q.size(), 0);
      repeat (8) @(negedge CLK);
   endtask

   task automatic hold_decode(int n);
      bit ok;
      int saved;
      wait_fetch(ok);
      if (ok) begin
         @(negedge CLK);
         saved = int'(pc);
         HOLD = 1'b1;
         disturbed = 1'b1;
         for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check("hold_strobes", int'({enable_current, enable_next}), 0);
            check("hold_pc", int'(pc), saved);
         end
         HOLD = 1'b0;
      end
   endtask

   task automatic expect_fault(int code);
      int n = 0;
      int frozen;
      while (!m_halted && n < 200) begin @(negedge CLK); n++; end
      check("halt_reached", int'(m_halted), 1);
      repeat (3) @(negedge CLK);
      check("fault", int'(fault), 1);
      check("fault_code", int'(fault_code), code);
      check("halt_pc", int'(pc), m_pc);
      check("halt_sp", int'(sp), m_stack.size());
      frozen = int'(pc);
      HOLD = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (i == 4) HOLD = 1'b0;
         check("halt_strobes", int'({enable_current, enable_next}), 0);
         check("halt_frozen_pc", int'(pc), frozen);
      end
   endtask

   initial begin
      bit ok;
      int d;
      int n;
      #1;
      // sequential flow
      reset_dut();
      repeat (4) stim_q.push_back(mk(1'b0, 1'b0, 10'd0));
      wait_drain(100);

      // call at pc 5 then return
      reset_dut();
      repeat (5) stim_q.push_back(mk(1'b0, 1'b0, 10'd0));
      stim_q.push_back(mk(1'b1, 1'b0, 10'h010));
      stim_q.push_back(mk(1'b0, 1'b1, 10'd0));
      wait_drain(200);

      // negative offset and pc wrap, then self-call and ret priority
      reset_dut();
      repeat (2) stim_q.push_back(mk(1'b0, 1'b0, 10'd0));
      stim_q.push_back(mk(1'b1, 1'b0, 10'h3FC));
      repeat (3) stim_q.push_back(mk(1'b0, 1'b0, 10'h155));
      stim_q.push_back(mk(1'b1, 1'b0, 10'h000));
      stim_q.push_back(mk(1'b1, 1'b1, 10'h0AA));
      wait_drain(200);

      // overflow: nine nested calls
      reset_dut();
      repeat (9) stim_q.push_back(mk(1'b1, 1'b0, 10'($urandom)));
      expect_fault(1);

      // underflow: return with empty stack
      reset_dut();
      stim_q.push_back(mk(1'b0, 1'b1, 10'd0));
      expect_fault(2);

      // hold during decode
      reset_dut();
      repeat (3) stim_q.push_back(mk(1'b1, 1'b0, 10'h007));
      hold_decode(5);
      wait_drain(200);

      // reset during update of a call aborts the push
      reset_dut();
      stim_q.push_back(mk(1'b0, 1'b0, 10'd0));
      stim_q.push_back(mk(1'b1, 1'b0, 10'h020));
      n = 0;
      while (stim_q.size() > 0 && n < 100) begin @(negedge CLK); n++; end
      n = 0;
      while (!enable_next && n < 20) begin @(negedge CLK); n++; end
      check("update_seen", int'(enable_next), 1);
      reset_dut();
      stim_q.push_back(mk(1'b0, 1'b1, 10'd0));
      expect_fault(2);

      // randomized flow with occasional decode holds
      reset_dut();
      d = 0;
      for (int i = 0; i < 300; i++) begin
         int    op;
         stim_t s;
         op = int'($urandom_range(0, 9));
         s = mk(1'b0, 1'b0, 10'($urandom));
         if (op < 3 && d < int'(DEPTH)) begin
            s.b = 1'b1;
            d++;
         end else if (op < 6 && d > 0) begin
            s.r = 1'b1;
            s.b = (op == 5);
            d--;
         end
         stim_q.push_back(s);
      end
      for (int k = 0; k < 30 && stim_q.size() > 0; k++) begin
         hold_decode(int'($urandom_range(1, 5)));
         repeat (int'($urandom_range(3, 20))) @(negedge CLK);
      end
      wait_drain(3000);
      check("final_fault", int'(fault), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
